// File: rtl/game_pkg.sv
// Shared types and helpers for the A/B digit-guessing controller.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_GUESS = 3'd2,
        ST_SCORE = 3'd3,
        ST_SHOW  = 3'd4,
        ST_OVER  = 3'd5
    } game_state_t;

    // All-ones pattern for a digit field of the given width; callers cast to DIGIT_W.
    function automatic logic [31:0] empty_marker(input int unsigned digit_w);
        return (32'd1 << digit_w) - 32'd1;
    endfunction

endpackage

// File: rtl/ab_score_engine.sv
// Sequential A/B scorer: walks slots NUM_DIGITS-1..0, one per cycle, after a start pulse.
module ab_score_engine #(
    parameter  int NUM_DIGITS = 4,
    parameter  int DIGIT_W    = 4,
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1),
    localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          start,
    input  logic                          abort,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] secret,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] guess,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              count_a,
    output logic [CNT_W-1:0]              count_b
);

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] s_arr;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] g_arr;
    logic [IDX_W-1:0]                   idx;
    logic [DIGIT_W-1:0]                 g_digit;
    logic                               hit_a;
    logic                               hit_any;

    assign s_arr = secret;
    assign g_arr = guess;

    always_comb begin
        g_digit = g_arr[idx];
        hit_a   = (g_digit == s_arr[idx]);
        hit_any = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (s_arr[k] == g_digit) hit_any = 1'b1;
        end
    end

    // done marks the cycle whose edge scores slot 0 and ends the pass.
    assign done = busy && (idx == '0);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            busy    <= 1'b0;
            idx     <= '0;
            count_a <= '0;
            count_b <= '0;
        end else if (abort) begin
            busy    <= 1'b0;
            idx     <= '0;
            count_a <= '0;
            count_b <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            idx     <= IDX_W'(NUM_DIGITS - 1);
            count_a <= '0;
            count_b <= '0;
        end else if (busy) begin
            if (hit_a)        count_a <= count_a + CNT_W'(1);
            else if (hit_any) count_b <= count_b + CNT_W'(1);
            if (idx == '0) busy <= 1'b0;
            else           idx  <= idx - IDX_W'(1);
        end
    end

endmodule

// File: rtl/guess_game_ctrl.sv
// A/B guessing-game controller: secret/guess entry, turn tracking, win/lose, internal scoring.
// Handshake: every control input is a one-cycle pulse sampled on CLK; restart > confirm > back.
module guess_game_ctrl
    import game_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int DIGIT_W    = 4,
    parameter  int MAX_DIGIT  = 9,
    parameter  int MAX_TURNS  = 6,
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1),
    localparam int IDX_W      = $clog2(NUM_DIGITS),
    localparam int TURN_W     = $clog2(MAX_TURNS + 1)
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          confirm_pulse,
    input  logic                          back_pulse,
    input  logic                          restart_pulse,
    input  logic [DIGIT_W-1:0]            digit_in,
    input  logic                          guess_enable,
    output logic [NUM_DIGITS*DIGIT_W-1:0] secret,
    output logic [NUM_DIGITS*DIGIT_W-1:0] guess,
    output logic [IDX_W-1:0]              cursor,
    output logic [CNT_W-1:0]              count_a,
    output logic [CNT_W-1:0]              count_b,
    output logic [TURN_W-1:0]             turn_count,
    output logic                          in_setup,
    output logic                          in_guess,
    output logic                          result_valid,
    output logic                          game_over,
    output logic                          win,
    output logic                          reject,
    output logic [2:0]                    state_dbg
);

    localparam logic [DIGIT_W-1:0] EMPTY       = DIGIT_W'(empty_marker(DIGIT_W));
    localparam logic [DIGIT_W-1:0] MAX_DIGIT_V = DIGIT_W'(MAX_DIGIT);
    localparam logic [IDX_W-1:0]   CUR_MSD     = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0][DIGIT_W-1:0] ALL_EMPTY = {NUM_DIGITS{EMPTY}};

    game_state_t                        state;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] sec_r;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] gss_r;
    logic                               win_r;
    logic                               reject_r;
    logic                               dup;
    logic                               digit_legal;
    logic [IDX_W-1:0]                   cursor_up;
    logic                               eng_start;
    logic                               eng_busy;
    logic                               eng_done;

    // Duplicate check only looks at the register being filled, ignoring empty slots.
    always_comb begin
        dup = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (state == ST_SETUP) begin
                if (sec_r[k] != EMPTY && sec_r[k] == digit_in) dup = 1'b1;
            end else begin
                if (gss_r[k] != EMPTY && gss_r[k] == digit_in) dup = 1'b1;
            end
        end
    end

    assign digit_legal = (digit_in <= MAX_DIGIT_V) && !dup &&
                         ((state == ST_SETUP) || guess_enable);
    assign cursor_up   = cursor + IDX_W'(1);
    assign eng_start   = (state == ST_GUESS) && confirm_pulse && !restart_pulse &&
                         digit_legal && (cursor == '0);

    ab_score_engine #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_W    (DIGIT_W)
    ) u_engine (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .start   (eng_start),
        .abort   (restart_pulse),
        .secret  (sec_r),
        .guess   (gss_r),
        .busy    (eng_busy),
        .done    (eng_done),
        .count_a (count_a),
        .count_b (count_b)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            sec_r      <= ALL_EMPTY;
            gss_r      <= ALL_EMPTY;
            cursor     <= '0;
            turn_count <= '0;
            win_r      <= 1'b0;
            reject_r   <= 1'b0;
        end else begin
            reject_r <= 1'b0;
            if (restart_pulse) begin
                state      <= ST_IDLE;
                sec_r      <= ALL_EMPTY;
                gss_r      <= ALL_EMPTY;
                cursor     <= '0;
                turn_count <= '0;
                win_r      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (confirm_pulse) begin
                            state      <= ST_SETUP;
                            cursor     <= CUR_MSD;
                            sec_r      <= ALL_EMPTY;
                            gss_r      <= ALL_EMPTY;
                            turn_count <= '0;
                            win_r      <= 1'b0;
                        end
                    end
                    ST_SETUP, ST_GUESS: begin
                        if (confirm_pulse) begin
                            if (digit_legal) begin
                                if (state == ST_SETUP) sec_r[cursor] <= digit_in;
                                else                   gss_r[cursor] <= digit_in;
                                if (cursor != '0) begin
                                    cursor <= cursor - IDX_W'(1);
                                end else if (state == ST_SETUP) begin
                                    state  <= ST_GUESS;
                                    cursor <= CUR_MSD;
                                    gss_r  <= ALL_EMPTY;
                                end else begin
                                    state      <= ST_SCORE;
                                    turn_count <= turn_count + TURN_W'(1);
                                end
                            end else begin
                                reject_r <= 1'b1;
                            end
                        end else if (back_pulse && cursor != CUR_MSD) begin
                            cursor <= cursor_up;
                            if (state == ST_SETUP) sec_r[cursor_up] <= EMPTY;
                            else                   gss_r[cursor_up] <= EMPTY;
                        end
                    end
                    ST_SCORE: begin
                        // An idle engine while scoring would otherwise strand the FSM.
                        if (eng_done || !eng_busy) state <= ST_SHOW;
                    end
                    ST_SHOW: begin
                        if (confirm_pulse) begin
                            if (count_a == CNT_W'(NUM_DIGITS)) begin
                                state <= ST_OVER;
                                win_r <= 1'b1;
                            end else if (turn_count == TURN_W'(MAX_TURNS)) begin
                                state <= ST_OVER;
                                win_r <= 1'b0;
                            end else begin
                                state  <= ST_GUESS;
                                cursor <= CUR_MSD;
                                gss_r  <= ALL_EMPTY;
                            end
                        end
                    end
                    ST_OVER: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign in_setup     = (state == ST_SETUP);
    assign in_guess     = (state == ST_GUESS);
    assign result_valid = (state == ST_SHOW);
    assign game_over    = (state == ST_OVER);
    assign win          = win_r;
    assign reject       = reject_r;
    assign state_dbg    = state;
    assign guess        = gss_r;
    // Secret stays hidden while the player is guessing or scoring.
    assign secret       = (in_setup || game_over) ? sec_r : ALL_EMPTY;

endmodule

// File: doc/guess_game_ctrl.md
# guess_game_ctrl

Parametrised controller for the digit-guessing (A/B) game: it collects a secret code and successive guesses, one digit per confirm pulse, and scores each guess with an internal sequential A/B engine. It tracks turns and declares win or lose. It sits between the debounced button-pulse / switch front end and the seven-segment/LED display logic. Scoring is internal, so the game no longer relies on an external A-count feedback path.

## Interface
Parameters:
- NUM_DIGITS, 4, code length (2..8)
- DIGIT_W, 4, bits per digit
- MAX_DIGIT, 9, largest legal digit value; must be < 2**DIGIT_W-1
- MAX_TURNS, 6, guesses allowed before loss (1..2**TURN_W-1)
- CNT_W = $clog2(NUM_DIGITS+1), IDX_W = $clog2(NUM_DIGITS), TURN_W = $clog2(MAX_TURNS+1) (derived, localparam)

Ports:
- CLK  in  1  clock
- RESET_N  in  1  reset (asynchronous, active-low)
- confirm_pulse  in  1  one-cycle pulse: accept digit_in / advance
- back_pulse  in  1  one-cycle pulse: erase previous digit
- restart_pulse  in  1  one-cycle pulse: synchronous return to IDLE
- digit_in  in  DIGIT_W  candidate digit
- guess_enable  in  1  guess digits are accepted only while high
- secret  out  NUM_DIGITS*DIGIT_W  secret digits; slot k at [k*DIGIT_W +: DIGIT_W], MSD = slot NUM_DIGITS-1
- guess  out  NUM_DIGITS*DIGIT_W  current guess, same packing
- cursor  out  IDX_W  slot currently being entered
- count_a, count_b  out  CNT_W  score of last guess
- turn_count  out  TURN_W  guesses submitted
- in_setup, in_guess, result_valid, game_over, win  out  1  phase flags
- reject  out  1  one-cycle pulse: confirm refused (duplicate, out of range, or guess_enable low)

## Operation
- Empty slot marker EMPTY = all-ones; registers hold EMPTY when unfilled.
- States: IDLE, SETUP, GUESS, SCORE, SHOW, OVER.
- IDLE: confirm -> SETUP, cursor = NUM_DIGITS-1, secret and guess all EMPTY, turn_count = 0.
- SETUP/GUESS confirm: legal when digit_in <= MAX_DIGIT, digit_in is not in any filled slot of the same register, and (GUESS only) guess_enable = 1.
  - Legal: write the slot at cursor. If cursor > 0, decrement cursor. If cursor = 0, SETUP -> GUESS (cursor reload, guess cleared) and GUESS -> SCORE.
  - Illegal: no state change; reject pulses.
- back: if cursor < NUM_DIGITS-1, cursor+1 and that slot := EMPTY. At the MSD slot, back is ignored; there is no cross-phase back into SETUP.
- SCORE: engine iterates i = NUM_DIGITS-1..0, one slot per cycle.
  - guess[i] == secret[i] -> A+1.
  - Else guess[i] equals any secret slot -> B+1.
  - turn_count increments on SCORE entry.
- SHOW: result_valid = 1 and the counts are stable. On confirm: if count_a == NUM_DIGITS -> OVER with win = 1; else if turn_count == MAX_TURNS -> OVER with win = 0; else -> GUESS with guess cleared and cursor reloaded.
- OVER: holds. Only restart leaves it.
- Priority: restart > confirm > back. When confirm and back are simultaneous, back is dropped.
- secret output is driven all-EMPTY while in_setup = 0 and game_over = 0, which hides the secret during guessing; the true value is shown in OVER.

## Timing
- Reset (async) and restart (sync, next edge) both produce: state IDLE, secret/guess EMPTY, cursor 0, counts 0, turn_count 0, all flags 0, reject 0.
- Digit write and cursor update are visible the cycle after the confirm edge.
- Scoring latency: SCORE lasts exactly NUM_DIGITS cycles. result_valid rises NUM_DIGITS+1 cycles after the final legal confirm.
- count_a and count_b clear on SCORE entry and are valid only while result_valid = 1.
- reject is registered and asserts the cycle after the refused confirm.
- Pulses arriving in SCORE are ignored, except restart.
- Restart mid-SCORE aborts the engine with no partial counts left.

## Structure
- game_pkg: state enum game_state_t and the EMPTY-marker function of DIGIT_W.
- Sub-module ab_score_engine (start, secret, guess -> busy, done, count_a, count_b). It is parameterised by NUM_DIGITS and DIGIT_W and holds the iterator and accumulators.
- The duplicate check is a combinational compare of digit_in against all NUM_DIGITS slots, gated by non-EMPTY.

## Test plan
Defaults apply: NUM_DIGITS=4, DIGIT_W=4, MAX_DIGIT=9, MAX_TURNS=6.
- Secret 1,2,3,4, guess 1,2,3,4 -> after 4 SCORE cycles count_a=4, count_b=0; confirm -> OVER, win=1, turn_count=1.
- Secret 1,2,3,4, guess 4,3,2,1 -> count_a=0, count_b=4; guess 1,3,2,5 -> count_a=1, count_b=2, turn_count=2.
- Secret entry 5,5 -> second confirm gives reject=1 and cursor stays 2. Digit 12 -> reject. Confirm with guess_enable=0 in GUESS -> reject.
- Enter 7,8 then back -> slot 2 = EMPTY and cursor=2. Back at cursor 3 -> no change. Confirm+back in the same cycle -> only the digit is written.
- Six wrong guesses -> sixth SHOW confirm -> OVER, win=0, game_over=1, and secret becomes visible.
- Restart during SCORE cycle 2, and async reset during GUESS -> all outputs return to reset values; the next confirm enters SETUP.
